// File: rtl/mdu_pkg.sv
// Shared MDU op encodings and default latencies for the E controller, hazard unit and mul_div_unit.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is sampled by the caller when it accepts an op.
module mdu_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo,
  output logic        div_by_zero
);
  import mdu_pkg::*;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps
    // cleanly to 0x80000000 instead of relying on simulator overflow rules.
    signed_div = (op == MDU_DIV);
    a_neg      = signed_div & a[31];
    b_neg      = signed_div & b[31];
    mag_a      = a_neg ? -a : a;
    mag_b      = b_neg ? -b : b;

    div_by_zero = is_div_op(op) && (b == 32'b0);
    quo         = (mag_b == 32'b0) ? 32'b0 : mag_a / mag_b;
    rem         = (mag_b == 32'b0) ? 32'b0 : mag_a % mag_b;
    quo_res     = (a_neg ^ b_neg) ? -quo : quo;
    rem_res     = a_neg ? -rem : rem;

    pend_hi = 32'b0;
    pend_lo = 32'b0;
    case (op)
      MDU_MULT: begin
        pend_hi = prod_s[63:32];
        pend_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        pend_hi = prod_u[63:32];
        pend_lo = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        pend_hi = rem_res;
        pend_lo = quo_res;
      end
      default: begin
        pend_hi = 32'b0;
        pend_lo = 32'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; mthi/mtlo write in one cycle.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES; HI/LO update as Busy falls.
// Backpressure: Busy is registered; Start/mthi/mtlo during a run are dropped.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_dbz;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_dbz;
  logic             long_op;
  logic             accept;
  logic [CNT_W-1:0] load_val;

  mdu_calc u_calc (
    .op          (MDUOp),
    .a           (A),
    .b           (B),
    .pend_hi     (calc_hi),
    .pend_lo     (calc_lo),
    .div_by_zero (calc_dbz)
  );

  // The completing cycle counts as idle for Start, so a chained op keeps
  // Busy high with no gap while HI/LO still commit the finished result.
  always_comb begin
    long_op  = is_mul_op(MDUOp) | is_div_op(MDUOp);
    accept   = Start && long_op && ((cnt == CNT_ZERO) || (cnt == CNT_ONE));
    load_val = is_mul_op(MDUOp) ? CNT_MUL : CNT_DIV;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= CNT_ZERO;
      Busy     <= 1'b0;
      HI       <= 32'b0;
      LO       <= 32'b0;
      pend_hi  <= 32'b0;
      pend_lo  <= 32'b0;
      pend_dbz <= 1'b0;
    end else begin
      if ((cnt == CNT_ONE) && !pend_dbz) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end

      if (accept) begin
        cnt      <= load_val;
        Busy     <= 1'b1;
        pend_hi  <= calc_hi;
        pend_lo  <= calc_lo;
        pend_dbz <= calc_dbz;
      end else if (cnt != CNT_ZERO) begin
        cnt  <= cnt - CNT_ONE;
        Busy <= (cnt != CNT_ONE);
      end else if (MDUOp == MDU_MTHI) begin
        HI <= A;
      end else if (MDUOp == MDU_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus directed multi-cycle sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int passed = 0;
  int total  = 0;
  logic [31:0] model_hi = 32'b0;
  logic [31:0] model_lo = 32'b0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
  endtask

  task automatic run_long(input int idx, input vec_t v);
    int   n;
    logic hold_ok;
    n = 0;
    hold_ok = 1'b1;
    issue(v.op, v.a, v.b);
    while (Busy && n < 40) begin
      if (HI !== model_hi || LO !== model_lo) hold_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk($sformatf("vec%0d_busy_cycles", idx), 32'(n), 32'(v.cycles));
    chk($sformatf("vec%0d_hold", idx), {31'b0, hold_ok}, 32'd1);
    chk($sformatf("vec%0d_hi", idx), HI, v.hi);
    chk($sformatf("vec%0d_lo", idx), LO, v.lo);
    model_hi = v.hi;
    model_lo = v.lo;
  endtask

  initial begin
    int n;
    vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MDU_DIVU,  32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{MDU_MULT,  32'h00000007, 32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{MDU_MULTU, 32'h80000000, 32'h00000002, 5,  32'h00000001, 32'h00000000};

    // Reset overrides mthi and a qualifying Start
    reset = 1'b0; Start = 1'b0; MDUOp = MDU_MTHI; A = 32'hDEADBEEF; B = 32'h5;
    @(negedge clk);
    MDUOp = MDU_MULT; Start = 1'b1;
    @(negedge clk);
    reset = 1'b1; Start = 1'b0; MDUOp = MDU_NONE;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    @(negedge clk);
    chk("rst_no_late_busy", {31'b0, Busy}, 32'd0);

    // Start with non-qualifying opcodes
    MDUOp = MDU_NONE; Start = 1'b1;
    @(negedge clk);
    chk("start_op0_busy", {31'b0, Busy}, 32'd0);
    MDUOp = 4'd9;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    chk("start_op9_busy", {31'b0, Busy}, 32'd0);
    chk("start_op9_hi", HI, 32'h0);

    for (int i = 0; i < 8; i++) run_long(i, vecs[i]);

    // mthi / mtlo then divide by zero
    @(negedge clk);
    MDUOp = MDU_MTHI; A = 32'h11111111;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h11111111);
    chk("mthi_busy", {31'b0, Busy}, 32'd0);
    MDUOp = MDU_MTLO; A = 32'h22222222;
    @(negedge clk);
    MDUOp = MDU_NONE;
    chk("mtlo_lo", LO, 32'h22222222);
    chk("mtlo_busy", {31'b0, Busy}, 32'd0);
    model_hi = 32'h11111111;
    model_lo = 32'h22222222;
    run_long(8, '{MDU_DIV, 32'h00000005, 32'h00000000, 10, 32'h11111111, 32'h22222222});

    // Start and mtlo while busy are ignored
    n = 0;
    issue(MDU_DIV, 32'd100, 32'd7);
    if (Busy) n++;
    @(negedge clk);
    if (Busy) n++;
    MDUOp = MDU_MULT; A = 32'd3; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    if (Busy) n++;
    Start = 1'b0; MDUOp = MDU_MTLO; A = 32'hBAD0BAD0;
    @(negedge clk);
    if (Busy) n++;
    MDUOp = MDU_NONE;
    chk("ign_mtlo_lo", LO, 32'h22222222);
    for (int g = 0; g < 40 && Busy; g++) begin
      @(negedge clk);
      if (Busy) n++;
    end
    chk("ign_busy_cycles", 32'(n), 32'd10);
    chk("ign_div_hi", HI, 32'h00000002);
    chk("ign_div_lo", LO, 32'h0000000E);

    // Reset in busy cycle 3 of a mult discards it
    issue(MDU_MULT, 32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_hi", HI, 32'h0);
    chk("midrst_lo", LO, 32'h0);
    repeat (8) @(negedge clk);
    chk("midrst_late_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_late_hi", HI, 32'h0);
    chk("midrst_late_lo", LO, 32'h0);

    // Back-to-back: Start in the completing cycle chains with no gap
    n = 0;
    issue(MDU_MULT, 32'd2, 32'd3);
    if (Busy) n++;
    repeat (4) begin
      @(negedge clk);
      if (Busy) n++;
    end
    MDUOp = MDU_MULTU; A = 32'd4; B = 32'd5; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    chk("b2b_first_lo", LO, 32'd6);
    chk("b2b_first_hi", HI, 32'd0);
    chk("b2b_busy_cont", {31'b0, Busy}, 32'd1);
    if (Busy) n++;
    for (int g = 0; g < 40 && Busy; g++) begin
      @(negedge clk);
      if (Busy) n++;
    end
    chk("b2b_busy_cycles", 32'(n), 32'd10);
    chk("b2b_second_hi", HI, 32'd0);
    chk("b2b_second_lo", LO, 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- E-stage multiply/divide unit of the 5-stage pipeline. Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu as multi-cycle operations, and mthi/mtlo as single-cycle writes.
- Drives the Busy input of the hazard/forwarding unit, which stalls muldiv-class instructions in D while E-stage Start or Busy is high.
- HI/LO feed mfhi/mflo through the E-stage result path into the M/W forwarding network.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu
DIV_CYCLES, 10, cycles Busy stays high for div/divu
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
MDUOp  input  4  op from E controller: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NONE
Start  input  1  one-cycle pulse from E controller, qualifying ops 1-4
A  input  32  rs operand (E-stage forwarded)
B  input  32  rt operand (E-stage forwarded)
Busy  output  1  operation in flight
HI  output  32  HI register, registered output
LO  output  32  LO register, registered output

Behaviour:
- Reset (reset==0 at a rising edge): HI=0, LO=0, Busy=0, counter=0, pending results=0. Reset overrides every other event, including a Start or mthi/mtlo in the same cycle.
- Reset mid-operation: the in-flight operation is discarded; HI/LO are not updated from it.
- States: IDLE (counter==0, Busy=0) and RUN (counter!=0, Busy=1). Busy is a registered output, never combinational from Start.
- IDLE -> RUN: edge with Start=1 and MDUOp in 1-4.
  - Counter loads MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
  - Pending HI/LO values are computed from A/B and latched at this edge.
  - Busy=1 from the following cycle.
- RUN: counter decrements each edge. On the edge where counter==1:
  - HI/LO <= pending values, counter=0, Busy=0.
  - Busy is therefore high exactly N cycles, and new HI/LO are visible in the same cycle Busy falls.
- MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
- MULTU: same with unsigned operands.
- DIV: signed, quotient truncated toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend (A).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B==0, op 3 or 4): full DIV_CYCLES busy period; HI/LO unchanged at completion.
- MTHI / MTLO: in IDLE, HI (or LO) <= A at the edge, regardless of Start. Busy stays 0.
- Ignored events (no state change):
  - Start or MTHI/MTLO while in RUN. The hazard unit guarantees this cannot occur.
  - Start with MDUOp 0, 5, 6 or 7-15.
- Back-to-back operations: a Start in the cycle Busy falls is accepted (state is IDLE). It loads the counter again, so Busy is low for 0 cycles and the next op uses the freshly written HI/LO.
- MFHI/MFLO reading in the cycle Busy falls sees the new values; reading while Busy=1 sees the old values. The hazard unit stalls such readers in D.

Decomposition:
- Shared package mdu_pkg holds:
  - MDUOp encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - MULT_CYCLES and DIV_CYCLES defaults.
  - The E controller and hazard-unit decoders reuse these encodings.
- One combinational sub-module, mdu_calc: (MDUOp, A, B) -> {pend_hi, pend_lo, div_by_zero}. It isolates signed/unsigned arithmetic from the counter/handshake logic.

Test Plan:
- Reset and MULT:
  - Stimulus: reset low 2 cycles, then MULT A=0xFFFFFFFE (-2), B=3, Start=1 for 1 cycle.
  - Required: Busy=1 for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA in the cycle Busy falls; HI/LO hold 0 during RUN.
- MULTU:
  - Stimulus: A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Required: after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- DIV and DIVU:
  - DIV A=-7 (0xFFFFFFF9), B=2: 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with the same operands: LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero:
  - Stimulus: MTHI A=0x11111111, MTLO A=0x22222222 on consecutive cycles, then DIV B=0.
  - Required: HI/LO update on the edge with Busy staying 0; Busy high 10 cycles; HI/LO remain 0x11111111/0x22222222 at completion.
- Ignored events:
  - Start MULT while Busy (cycle 2 of a DIV), and MTLO while Busy.
  - Required: both ignored; DIV completes after the original 10 cycles with the correct result; LO is not overwritten by the MTLO.
- Reset mid-op and back-to-back:
  - Reset low at busy cycle 3 of a MULT: next cycle Busy=0, HI=LO=0, no later update.
  - Start MULT in the cycle Busy falls from a previous MULT: the second op is accepted and Busy is continuous for 10 cycles total.
